// File: rtl/airlock_pkg.sv
// Shared types and constants for the airlock sequencer: state encoding,
// display phase codes, default phase durations and timer load width.
package airlock_pkg;

    localparam int TMR_W = 10;

    localparam logic [TMR_W-1:0] FILL_SEC_DEF  = 10'd420;
    localparam logic [TMR_W-1:0] DRAIN_SEC_DEF = 10'd480;
    localparam logic [TMR_W-1:0] ENTRY_SEC_DEF = 10'd300;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_FILL  = 3'd1;
    localparam logic [2:0] PH_OUTER = 3'd2;
    localparam logic [2:0] PH_DRAIN = 3'd3;
    localparam logic [2:0] PH_INNER = 3'd4;
    localparam logic [2:0] PH_ESTOP = 3'd7;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FILL_LD  = 4'd1,
        FILL_WT  = 4'd2,
        OUTER_LD = 4'd3,
        OUTER_WT = 4'd4,
        DRAIN_LD = 4'd5,
        DRAIN_WT = 4'd6,
        INNER_LD = 4'd7,
        INNER_WT = 4'd8,
        ESTOP    = 4'd9
    } state_t;

    // Successor of a finished WAIT state: arrival runs FILL-OUTER-DRAIN-INNER,
    // departure runs INNER-FILL-OUTER-DRAIN.
    function automatic state_t next_phase(input state_t cur, input logic dir);
        state_t nxt;
        case (cur)
            FILL_WT:  nxt = OUTER_LD;
            OUTER_WT: nxt = DRAIN_LD;
            DRAIN_WT: nxt = dir ? IDLE : INNER_LD;
            INNER_WT: nxt = dir ? FILL_LD : IDLE;
            default:  nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/airlock_ctrl_if.sv
// Request, timer and actuator signals of the airlock sequencer.
// The estop input exists only when AIRLOCK_ESTOP_EN is defined.
interface airlock_ctrl_if;
    logic                           arrive_req;
    logic                           depart_req;
    logic                           door_clear;
    logic                           tmr_done;
    logic                           tmr_start;
    logic [airlock_pkg::TMR_W-1:0]  tmr_seconds;
    logic                           outer_open;
    logic                           inner_open;
    logic                           fill_valve;
    logic                           drain_valve;
    logic                           busy;
    logic                           dir;
    logic [2:0]                     phase;
`ifdef AIRLOCK_ESTOP_EN
    logic                           estop;
`endif

    modport master (
`ifdef AIRLOCK_ESTOP_EN
        input  estop,
`endif
        input  arrive_req, depart_req, door_clear, tmr_done,
        output tmr_start, tmr_seconds, outer_open, inner_open,
        output fill_valve, drain_valve, busy, dir, phase
    );

    modport slave (
`ifdef AIRLOCK_ESTOP_EN
        output estop,
`endif
        output arrive_req, depart_req, door_clear, tmr_done,
        input  tmr_start, tmr_seconds, outer_open, inner_open,
        input  fill_valve, drain_valve, busy, dir, phase
    );
endinterface

// File: rtl/airlock_ctrl.sv
// Two-door airlock sequencer: fill / door / drain phases timed by an external
// countdown timer. Define AIRLOCK_ESTOP_EN to add the emergency-stop state.
module airlock_ctrl
    import airlock_pkg::*;
#(
    parameter logic [TMR_W-1:0] FILL_SEC  = FILL_SEC_DEF,
    parameter logic [TMR_W-1:0] DRAIN_SEC = DRAIN_SEC_DEF,
    parameter logic [TMR_W-1:0] ENTRY_SEC = ENTRY_SEC_DEF
) (
    input  logic          clk,
    input  logic          reset,
    airlock_ctrl_if.master bus
);

    state_t             state_r, next_state_s;
    logic               dir_r, next_dir_s;
    logic               estop_hit_s;
    logic [2:0]         phase_s;
    logic               start_s, outer_s, inner_s, fill_s, drain_s, busy_s;
    logic [TMR_W-1:0]   secs_s;

`ifdef AIRLOCK_ESTOP_EN
    logic               rec_r, next_rec_s;
    assign estop_hit_s = bus.estop && (state_r != IDLE);
`else
    assign estop_hit_s = 1'b0;
`endif

    assign bus.dir = dir_r;

    // Next-state logic: request capture in IDLE, phase stepping on timer done.
    always_comb begin
        next_state_s = state_r;
        next_dir_s   = dir_r;
`ifdef AIRLOCK_ESTOP_EN
        next_rec_s   = rec_r;
`endif
        if (estop_hit_s) begin
            next_state_s = ESTOP;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.arrive_req) begin
                        next_state_s = FILL_LD;
                        next_dir_s   = 1'b0;
                    end else if (bus.depart_req) begin
                        next_state_s = INNER_LD;
                        next_dir_s   = 1'b1;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                FILL_LD:  next_state_s = FILL_WT;
                OUTER_LD: next_state_s = OUTER_WT;
                DRAIN_LD: next_state_s = DRAIN_WT;
                INNER_LD: next_state_s = INNER_WT;
                FILL_WT: begin
                    if (bus.tmr_done) next_state_s = next_phase(state_r, dir_r);
                    else              next_state_s = FILL_WT;
                end
                DRAIN_WT: begin
                    if (!bus.tmr_done) begin
                        next_state_s = DRAIN_WT;
`ifdef AIRLOCK_ESTOP_EN
                    end else if (rec_r) begin
                        // Recovery drain after an emergency stop ends the sequence.
                        next_state_s = IDLE;
                        next_rec_s   = 1'b0;
`endif
                    end else begin
                        next_state_s = next_phase(state_r, dir_r);
                    end
                end
                // A door only closes once the doorway is clear.
                OUTER_WT, INNER_WT: begin
                    if (bus.tmr_done && bus.door_clear) next_state_s = next_phase(state_r, dir_r);
                    else                                next_state_s = state_r;
                end
`ifdef AIRLOCK_ESTOP_EN
                ESTOP: begin
                    next_state_s = DRAIN_LD;
                    next_rec_s   = 1'b1;
                end
`endif
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Output decode of the upcoming state, so the registered outputs track the state register.
    always_comb begin
        phase_s = PH_IDLE;
        start_s = 1'b0;
        secs_s  = {TMR_W{1'b0}};
        outer_s = 1'b0;
        inner_s = 1'b0;
        fill_s  = 1'b0;
        drain_s = 1'b0;
        busy_s  = (next_state_s != IDLE);
        case (next_state_s)
            FILL_LD:  begin phase_s = PH_FILL;  start_s = 1'b1; secs_s = FILL_SEC;  fill_s  = 1'b1; end
            FILL_WT:  begin phase_s = PH_FILL;  fill_s  = 1'b1; end
            OUTER_LD: begin phase_s = PH_OUTER; start_s = 1'b1; secs_s = ENTRY_SEC; outer_s = 1'b1; end
            OUTER_WT: begin phase_s = PH_OUTER; outer_s = 1'b1; end
            DRAIN_LD: begin phase_s = PH_DRAIN; start_s = 1'b1; secs_s = DRAIN_SEC; drain_s = 1'b1; end
            DRAIN_WT: begin phase_s = PH_DRAIN; drain_s = 1'b1; end
            INNER_LD: begin phase_s = PH_INNER; start_s = 1'b1; secs_s = ENTRY_SEC; inner_s = 1'b1; end
            INNER_WT: begin phase_s = PH_INNER; inner_s = 1'b1; end
`ifdef AIRLOCK_ESTOP_EN
            ESTOP:    begin phase_s = PH_ESTOP; end
`endif
            default:  begin phase_s = PH_IDLE; end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= IDLE;
            dir_r           <= 1'b0;
            bus.phase       <= PH_IDLE;
            bus.tmr_start   <= 1'b0;
            bus.tmr_seconds <= {TMR_W{1'b0}};
            bus.outer_open  <= 1'b0;
            bus.inner_open  <= 1'b0;
            bus.fill_valve  <= 1'b0;
            bus.drain_valve <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            state_r         <= next_state_s;
            dir_r           <= next_dir_s;
            bus.phase       <= phase_s;
            bus.tmr_start   <= start_s;
            bus.tmr_seconds <= secs_s;
            bus.outer_open  <= outer_s;
            bus.inner_open  <= inner_s;
            bus.fill_valve  <= fill_s;
            bus.drain_valve <= drain_s;
            bus.busy        <= busy_s;
        end
    end

`ifdef AIRLOCK_ESTOP_EN
    // Remembers that the current drain is the post-emergency recovery drain.
    always_ff @(posedge clk) begin
        if (!reset) rec_r <= 1'b0;
        else        rec_r <= next_rec_s;
    end
`endif

endmodule

// File: tb/tb_airlock_ctrl.sv
// Bench for airlock_ctrl: timer model, table-driven sequences, corner cases,
// and randomized traffic against a phase-list reference model.
module tb_airlock_ctrl;
    import airlock_pkg::*;

    localparam logic [9:0] TB_FILL  = 10'd3;
    localparam logic [9:0] TB_DRAIN = 10'd4;
    localparam logic [9:0] TB_ENTRY = 10'd2;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;
    logic [9:0] tcnt;

    always #5 clk = ~clk;

    airlock_ctrl_if bus();

    airlock_ctrl #(.FILL_SEC(TB_FILL), .DRAIN_SEC(TB_DRAIN), .ENTRY_SEC(TB_ENTRY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Countdown timer: load on start, otherwise count down to zero.
    always @(posedge clk) begin
        if (!reset)                tcnt <= 10'd0;
        else if (bus.tmr_start)    tcnt <= bus.tmr_seconds;
        else if (tcnt != 10'd0)    tcnt <= tcnt - 10'd1;
    end
    assign bus.tmr_done = (tcnt == 10'd0);

    function automatic logic [9:0] secs_of(input logic [2:0] ph);
        case (ph)
            3'd1:    return TB_FILL;
            3'd2:    return TB_ENTRY;
            3'd3:    return TB_DRAIN;
            3'd4:    return TB_ENTRY;
            default: return 10'd0;
        endcase
    endfunction

    // {phase, tmr_start, tmr_seconds, busy, dir, outer, inner, fill, drain}
    function automatic logic [19:0] exp_vec(input logic [2:0] ph, input logic st,
                                            input logic bsy, input logic dr);
        logic [9:0] s;
        s = st ? secs_of(ph) : 10'd0;
        return {ph, st, s, bsy, dr, ph == 3'd2, ph == 3'd4, ph == 3'd1, ph == 3'd3};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {bus.phase, bus.tmr_start, bus.tmr_seconds, bus.busy, bus.dir,
                bus.outer_open, bus.inner_open, bus.fill_valve, bus.drain_valve};
    endfunction

    task automatic check(input string name, input logic [19:0] got, input logic [19:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Reference model: position in the phase list of the chosen direction.
    logic m_busy = 1'b0, m_dir = 1'b0, m_load = 1'b0, m_est = 1'b0, m_rec = 1'b0;
    logic [2:0] m_ph = 3'd0;
    int m_el = 0;

    function automatic logic [2:0] seq_next(input logic d, input logic [2:0] ph);
        logic [2:0] s [4];
        if (d) s = '{3'd4, 3'd1, 3'd2, 3'd3};
        else   s = '{3'd1, 3'd2, 3'd3, 3'd4};
        for (int i = 0; i < 3; i++) if (s[i] == ph) return s[i+1];
        return 3'd0;
    endfunction

    task automatic model_step();
        logic es;
        logic [2:0] nx;
`ifdef AIRLOCK_ESTOP_EN
        es = bus.estop;
`else
        es = 1'b0;
`endif
        if (!reset) begin
            m_busy = 1'b0; m_dir = 1'b0; m_ph = 3'd0; m_load = 1'b0; m_est = 1'b0; m_rec = 1'b0;
        end else if (!m_busy) begin
            if (bus.arrive_req)      begin m_busy = 1'b1; m_dir = 1'b0; m_ph = 3'd1; m_load = 1'b1; end
            else if (bus.depart_req) begin m_busy = 1'b1; m_dir = 1'b1; m_ph = 3'd4; m_load = 1'b1; end
        end else if (es) begin
            m_est = 1'b1;
        end else if (m_est) begin
            m_est = 1'b0; m_rec = 1'b1; m_ph = 3'd3; m_load = 1'b1;
        end else if (m_load) begin
            m_load = 1'b0; m_el = 0;
        end else begin
            m_el++;
            if (m_el >= int'(secs_of(m_ph)) + 1 &&
                (!(m_ph == 3'd2 || m_ph == 3'd4) || bus.door_clear)) begin
                nx = (m_rec && m_ph == 3'd3) ? 3'd0 : seq_next(m_dir, m_ph);
                if (nx == 3'd0) begin m_busy = 1'b0; m_rec = 1'b0; end
                else            begin m_ph = nx; m_load = 1'b1; end
            end
        end
    endtask

    function automatic logic [19:0] model_vec();
        return exp_vec(m_est ? 3'd7 : (m_busy ? m_ph : 3'd0),
                       m_busy && !m_est && m_load, m_busy, m_dir);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_until_idle(input string name);
        int k = 0;
        while (bus.busy && k < 200) begin tick(); k++; end
        n_cmp++;
        if (bus.busy) begin
            n_bad++;
            $display("FAIL %s: busy=%b after %0d cycles, expected 0", name, bus.busy, k);
        end
    endtask

    task automatic wait_wait_phase(input string name, input logic [2:0] ph);
        int k = 0;
        while (!(bus.phase == ph && !bus.tmr_start) && k < 200) begin tick(); k++; end
        n_cmp++;
        if (!(bus.phase == ph && !bus.tmr_start)) begin
            n_bad++;
            $display("FAIL %s: phase=%0d, expected WAIT of phase %0d", name, bus.phase, ph);
        end
    endtask

    // Doors and valves are mutually exclusive at all times.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if ((bus.outer_open && bus.inner_open) || (bus.fill_valve && bus.drain_valve)) begin
                n_bad++;
                $display("FAIL excl: doors %b%b valves %b%b, expected no pair both 1",
                         bus.outer_open, bus.inner_open, bus.fill_valve, bus.drain_valve);
            end
        end
    end

    typedef struct {
        logic       arr;
        logic       dep;
        logic [2:0] ph;
        logic       st;
        logic       bsy;
        logic       dr;
    } vec_t;
    vec_t tbl[$];

    task automatic add_phase(input logic arr, input logic dep, input logic [2:0] ph,
                             input logic dr, input int waits);
        tbl.push_back('{arr, dep, ph, 1'b1, 1'b1, dr});
        for (int i = 0; i < waits; i++) tbl.push_back('{1'b0, 1'b0, ph, 1'b0, 1'b1, dr});
    endtask

    task automatic add_idle(input logic dr);
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, dr});
    endtask

    initial begin
        int dep_row;
        // Arrival: WAIT lengths 4,3,5,3.
        add_phase(1'b1, 1'b0, 3'd1, 1'b0, 4); add_phase(1'b0, 1'b0, 3'd2, 1'b0, 3);
        add_phase(1'b0, 1'b0, 3'd3, 1'b0, 5); add_phase(1'b0, 1'b0, 3'd4, 1'b0, 3);
        add_idle(1'b0);
        // Departure: 19 busy cycles.
        add_phase(1'b0, 1'b1, 3'd4, 1'b1, 3); add_phase(1'b0, 1'b0, 3'd1, 1'b1, 4);
        add_phase(1'b0, 1'b0, 3'd2, 1'b1, 3); add_phase(1'b0, 1'b0, 3'd3, 1'b1, 5);
        add_idle(1'b1);
        // Both requests: arrival wins; depart during FILL ignored.
        add_phase(1'b1, 1'b1, 3'd1, 1'b0, 4);
        dep_row = tbl.size() - 2;
        tbl[dep_row].dep = 1'b1;
        add_phase(1'b0, 1'b0, 3'd2, 1'b0, 3); add_phase(1'b0, 1'b0, 3'd3, 1'b0, 5);
        add_phase(1'b0, 1'b0, 3'd4, 1'b0, 3); add_idle(1'b0); add_idle(1'b0);

        reset = 1'b0;
        bus.arrive_req = 1'b0; bus.depart_req = 1'b0; bus.door_clear = 1'b1;
`ifdef AIRLOCK_ESTOP_EN
        bus.estop = 1'b0;
`endif
        tick(); tick();
        check("reset", dut_vec(), exp_vec(3'd0, 1'b0, 1'b0, 1'b0));
        mon_en = 1'b1;
        reset = 1'b1;
        tick();
        check("idle", dut_vec(), exp_vec(3'd0, 1'b0, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            bus.arrive_req = tbl[i].arr;
            bus.depart_req = tbl[i].dep;
            tick();
            check($sformatf("tbl%0d", i), dut_vec(),
                  exp_vec(tbl[i].ph, tbl[i].st, tbl[i].bsy, tbl[i].dr));
        end
        bus.arrive_req = 1'b0; bus.depart_req = 1'b0;

        // Outer door held open by an obstruction for 5 extra cycles.
        bus.arrive_req = 1'b1; tick(); bus.arrive_req = 1'b0;
        wait_wait_phase("reach_outer", 3'd2);
        bus.door_clear = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("door_hold%0d", i), dut_vec(), exp_vec(3'd2, 1'b0, 1'b1, 1'b0));
        end
        bus.door_clear = 1'b1;
        tick();
        check("door_close", dut_vec(), exp_vec(3'd3, 1'b1, 1'b1, 1'b0));
        run_until_idle("door_seq_end");

        // Reset during DRAIN WAIT, then restart.
        bus.arrive_req = 1'b1; tick(); bus.arrive_req = 1'b0;
        wait_wait_phase("reach_drain", 3'd3);
        tick();
        reset = 1'b0; tick();
        check("mid_reset", dut_vec(), exp_vec(3'd0, 1'b0, 1'b0, 1'b0));
        reset = 1'b1;
        bus.arrive_req = 1'b1; tick(); bus.arrive_req = 1'b0;
        check("restart_fill", dut_vec(), exp_vec(3'd1, 1'b1, 1'b1, 1'b0));
        run_until_idle("restart_end");

`ifdef AIRLOCK_ESTOP_EN
        // Emergency stop during OUTER, recovery through DRAIN.
        bus.arrive_req = 1'b1; tick(); bus.arrive_req = 1'b0;
        wait_wait_phase("reach_outer_es", 3'd2);
        bus.estop = 1'b1;
        tick(); check("estop0", dut_vec(), exp_vec(3'd7, 1'b0, 1'b1, 1'b0));
        tick(); check("estop1", dut_vec(), exp_vec(3'd7, 1'b0, 1'b1, 1'b0));
        bus.estop = 1'b0;
        tick(); check("estop_drain_ld", dut_vec(), exp_vec(3'd3, 1'b1, 1'b1, 1'b0));
        for (int i = 0; i < 5; i++) begin
            tick(); check($sformatf("estop_drain%0d", i), dut_vec(), exp_vec(3'd3, 1'b0, 1'b1, 1'b0));
        end
        tick(); check("estop_idle", dut_vec(), exp_vec(3'd0, 1'b0, 1'b0, 1'b0));
`endif

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            bus.arrive_req = ($urandom_range(7) == 0);
            bus.depart_req = ($urandom_range(7) == 0);
            bus.door_clear = ($urandom_range(3) != 0);
            reset          = ($urandom_range(299) != 0);
`ifdef AIRLOCK_ESTOP_EN
            if (bus.estop) bus.estop = ($urandom_range(3) != 0);
            else           bus.estop = ($urandom_range(79) == 0);
`endif
            tick();
            check($sformatf("rand%0d", c), dut_vec(), model_vec());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/airlock_ctrl.md
# airlock_ctrl

Sequencing FSM for the two-door airlock chamber. Accepts arrival and departure requests, drives door and valve outputs through fill, door-open and drain phases, and times each phase with the external countdown timer. It issues that timer's start pulse and load value and consumes its done flag. All logic runs on the same 1 Hz `clk` as the timer.

## Interface
- `FILL_SEC`, default 420: seconds to flood the chamber to outside level (10-bit).
- `DRAIN_SEC`, default 480: seconds to pump the chamber back to inside level (10-bit).
- `ENTRY_SEC`, default 300: minimum seconds a door stays open (10-bit).
- `clk` in 1: system clock, 1 Hz.
- `reset` in 1: synchronous, active-low.
- `arrive_req` in 1: level; vehicle outside requests entry.
- `depart_req` in 1: level; vehicle inside requests exit.
- `door_clear` in 1: high when no obstruction is in either doorway.
- `tmr_done` in 1: timer done flag; high when the timer count is 0.
- `tmr_start` out 1: one-cycle load/start pulse to the timer.
- `tmr_seconds` out 10: load value for the timer, held stable while `tmr_start` is high.
- `outer_open` out 1: outer (water-side) door open.
- `inner_open` out 1: inner (station-side) door open.
- `fill_valve` out 1: flood valve on.
- `drain_valve` out 1: pump on.
- `busy` out 1: high in every state except IDLE.
- `dir` out 1: 0 = arrival sequence, 1 = departure sequence.
- `phase` out 3: phase code for display. 0 IDLE, 1 FILL, 2 OUTER, 3 DRAIN, 4 INNER, 7 ESTOP.

## Operation
- Each timed phase is a LOAD state followed by a WAIT state.
  - LOAD: `tmr_start`=1 and `tmr_seconds`=phase value.
  - WAIT: `tmr_start`=0. The FSM advances when `tmr_done`=1.
- Phase outputs:
  - FILL: `fill_valve`=1.
  - DRAIN: `drain_valve`=1.
  - OUTER: `outer_open`=1.
  - INNER: `inner_open`=1.
- The two doors are never open together, and the two valves are never on together.
- Arrival sequence (`dir`=0): IDLE → FILL → OUTER → DRAIN → INNER → IDLE.
- Departure sequence (`dir`=1): IDLE → INNER → FILL → OUTER → DRAIN → IDLE.
- Door phase end: after `tmr_done`, the door closes only if `door_clear`=1. Otherwise the FSM stays in the door WAIT state with the door open until `door_clear` rises.
- Requests are sampled only in IDLE and ignored while `busy`.
  - If `arrive_req` and `depart_req` are both high in IDLE, arrival wins.
  - `dir` is latched when leaving IDLE.
- A load value of 0 gives a WAIT of exactly 1 cycle.
- Reset: all outputs 0, state IDLE. Reset mid-sequence closes both doors and turns off both valves on the next edge. The chamber is treated as dry after reset.

## Timing
- All outputs are registered Moore outputs of the current state.
- Request high in IDLE at edge n → LOAD state and `tmr_start`=1 in cycle n+1.
- `tmr_start` is high for exactly one cycle per phase. The timer loads on the edge ending LOAD.
- In the first WAIT cycle, `tmr_done` already reflects the new count, so no blanking cycle is needed.
- Phase length with value S: 1 LOAD cycle + (S+1) WAIT cycles. Door phases add any extra cycles spent waiting for `door_clear`.
- Back-to-back phases: the last WAIT cycle of one phase is followed directly by the LOAD of the next. Door and valve outputs change on that same edge.
- Return to IDLE: `busy` drops on the edge after the final WAIT's done. A request held high is accepted again one cycle later.

## Configuration
- `AIRLOCK_ESTOP_EN` defined: adds input `estop` (1 bit, active high).
  - `estop` in any non-IDLE state → ESTOP on the next edge. ESTOP: doors closed, valves off, `phase`=7, `tmr_start`=0.
  - On `estop` low, ESTOP → DRAIN LOAD. The sequence then completes as DRAIN → IDLE.
  - `estop` in IDLE is ignored.
- `AIRLOCK_ESTOP_EN` undefined: no `estop` port, no ESTOP state, and code 7 is never driven.

## Structure
- Package `airlock_pkg` holds:
  - the state enum: IDLE, FILL_LD, FILL_WT, OUTER_LD, OUTER_WT, DRAIN_LD, DRAIN_WT, INNER_LD, INNER_WT, ESTOP;
  - the 3-bit phase code constants;
  - the default second constants 420/480/300;
  - the timer width constant (10).
- Sub-modules: none inside the block. The countdown timer is instantiated alongside in the top level.
- Next-phase selection is a function of current phase and `dir`.

## Test plan
Bench parameters: `FILL_SEC`=3, `DRAIN_SEC`=4, `ENTRY_SEC`=2. The bench includes a behavioural timer model: on `tmr_start` it loads the value; otherwise it decrements once per cycle while nonzero; done = (count == 0).

1. Arrival: `arrive_req` pulse in IDLE → phases 1,2,3,4,0 with WAIT lengths 4,3,5,3 cycles. `outer_open` and `inner_open` are never both high. `tmr_start` is asserted exactly 4 times.
2. Departure: `depart_req` → phases 4,1,2,3,0, `dir`=1. Total `busy` time = 4 LOAD cycles + 3+4+3+5 WAIT cycles = 19 cycles.
3. Simultaneous `arrive_req`=`depart_req`=1 in IDLE → `dir`=0. `depart_req` pulsed during FILL is ignored, and the FSM returns to IDLE afterwards.
4. `door_clear`=0 at the end of the OUTER timer → `outer_open` stays 1 for 5 extra cycles. The door closes on the edge after `door_clear` rises.
5. Reset low during the DRAIN WAIT → next cycle all outputs are 0 and `phase`=0. After reset is released, an arrival request restarts at FILL.
6. With `AIRLOCK_ESTOP_EN`: `estop` high during OUTER → both doors and valves off, `phase`=7. On release → DRAIN (5 WAIT cycles) → IDLE.
